// File: rtl/gray_conv_pkg.sv
// gray_conv_pkg: shared types, defaults and bit helpers for the Gray-conversion arbiter
package gray_conv_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ = 4;
  localparam int MAXW = 32;
  typedef enum logic {EMPTY, FULL} slot_t;
  function automatic logic [MAXW-1:0] gray2bin(input logic [MAXW-1:0] g);
    logic [MAXW-1:0] b;
    b[MAXW-1] = g[MAXW-1];
    for (int i = MAXW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  function automatic logic [5:0] popcount(input logic [MAXW-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < MAXW; i++) c = c + 6'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/gray_conv_arbiter_rr.sv
// rr_arbiter: round-robin one-hot grant searching upward from ptr with wrap
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any_grant
);
  int j;
  always_comb begin
    grant = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    j = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (en && req[j]) begin
        grant = NREQ'(1) << j;
        grant_idx = IDW'(j);
        any_grant = 1'b1;
      end
    end
  end
endmodule

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: round-robin shared Gray-to-binary converter with registered response
// Optional sticky Gray-step checking per requester is enabled by GRAY_ERR_CHK_EN.
module gray_conv_arbiter
  import gray_conv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ = DEF_NREQ,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_gray,
  output logic [NREQ-1:0]       req_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WIDTH-1:0]      resp_binary,
  output logic [IDW-1:0]        resp_id,
  output logic [NREQ-1:0]       err_status,
  input  logic [NREQ-1:0]       err_clr
);
  slot_t state, state_nxt;
  logic [IDW-1:0] ptr, gnt_idx;
  logic any_grant, can_accept;
  logic [WIDTH-1:0] gnt_gray, gnt_bin;
  assign can_accept = state == EMPTY || resp_ready;
  assign resp_valid = state == FULL;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req(req_valid),
    .en(can_accept),
    .ptr(ptr),
    .grant(req_ready),
    .grant_idx(gnt_idx),
    .any_grant(any_grant)
  );
  assign gnt_gray = req_gray[gnt_idx*WIDTH +: WIDTH];
  assign gnt_bin = WIDTH'(gray2bin(MAXW'(gnt_gray)));
  always_comb state_nxt = any_grant ? FULL : (resp_ready ? EMPTY : state);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= EMPTY;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_binary <= '0;
      resp_id <= '0;
      ptr <= '0;
    end else if (any_grant) begin
      resp_binary <= gnt_bin;
      resp_id <= gnt_idx;
      ptr <= gnt_idx == IDW'(NREQ - 1) ? '0 : gnt_idx + 1'b1;
    end
  end
`ifdef GRAY_ERR_CHK_EN
  logic [WIDTH-1:0] hist [NREQ];
  logic [NREQ-1:0] seen, err_set;
  // a legal Gray step flips at most one bit; repeats are also tolerated
  assign err_set = (any_grant && seen[gnt_idx] &&
                    popcount(MAXW'(hist[gnt_idx] ^ gnt_gray)) > 6'd1) ? req_ready : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen <= '0;
      err_status <= '0;
      for (int i = 0; i < NREQ; i++) hist[i] <= '0;
    end else begin
      err_status <= (err_status & ~err_clr) | err_set;
      if (any_grant) begin
        hist[gnt_idx] <= gnt_gray;
        seen[gnt_idx] <= 1'b1;
      end
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = ^err_clr;
  assign err_status = '0;
`endif
endmodule

// File: doc/gray_conv_arbiter.md
Name: gray_conv_arbiter

Overview:
- Shares one Gray-to-binary conversion datapath among NREQ requesters, for example async-FIFO pointer readers or rotary-encoder samplers.
- A round-robin grant picks one valid request per cycle, converts its Gray word and returns the binary result with the requester ID on a single response channel.
- Sits between the synchronised Gray-coded sources and the downstream consumers of binary counts.

Parameters:
- WIDTH, 8, Gray/binary word width (>=2).
- NREQ, 4, number of requesters (2..16).
- IDW, $clog2(NREQ), width of the requester ID field (derived, not overridden).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_gray  in  NREQ*WIDTH  packed Gray words; requester i occupies [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  one-hot grant/accept; bit i high means requester i is accepted this cycle.
- resp_valid  out  1  response register holds a result.
- resp_ready  in  1  downstream accepts the response.
- resp_binary  out  WIDTH  converted binary value.
- resp_id  out  IDW  index of the requester that produced resp_binary.
- err_status  out  NREQ  sticky Gray-sequence error per requester (GRAY_ERR_CHK_EN only; else tied 0).
- err_clr  in  NREQ  per-bit clear of err_status (ignored without GRAY_ERR_CHK_EN).

Behaviour:
- Reset (async on rst_n low): resp_valid=0, resp_binary=0, resp_id=0, err_status=0, round-robin pointer=0, all per-requester history cleared. req_ready is combinational and 0 while resp_valid=1 and resp_ready=0.
- Conversion: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i] (prefix XOR from MSB).
  - Pure combinational on the granted word; result registered.
- Slot free condition: can_accept = !resp_valid || resp_ready.
- Arbitration: when can_accept, grant = first i with req_valid[i], searching from ptr upward with wrap at NREQ-1 to 0.
  - req_ready is one-hot at the granted bit and 0 elsewhere; 0 if no valid request or !can_accept.
  - req_ready never asserts for a requester whose req_valid=0.
- Transfer on grant: register resp_binary=conv(req_gray[grant]), resp_id=grant, resp_valid=1, ptr=(grant+1) mod NREQ.
- Latency: 1 cycle from accept to resp_valid. Throughput: 1 result/cycle while resp_ready=1.
- State machine (output slot):
  - EMPTY --grant--> FULL.
  - FULL --resp_ready & grant--> FULL (new data, back-to-back).
  - FULL --resp_ready & no grant--> EMPTY.
  - FULL --!resp_ready--> FULL; resp_binary/resp_id held stable.
- Pointer: unchanged when there is no grant.
  - A single continuously valid requester is granted every cycle.
  - With all NREQ valid, grants rotate 0,1,..,NREQ-1,0.
- Requesters must hold req_valid/req_gray until their req_ready; dropping req_valid before grant is allowed and simply loses arbitration.
- Reset mid-transfer: pending response discarded; no response emitted for the in-flight grant.

Optional Feature:
- Macro GRAY_ERR_CHK_EN.
- Defined:
  - Per requester, store the last accepted Gray word plus a seen bit (cleared at reset).
  - On each accept of requester i with seen=1, compute the Hamming distance to the stored word; distance >1 sets err_status[i]. Distance 0 or 1 is legal.
  - First accept after reset is never checked.
  - err_clr[i] clears err_status[i]; if set and clear occur in the same cycle, set wins.
  - The response is still produced normally.
- Undefined: no history storage; err_status tied to 0; err_clr unused.

Decomposition:
- Package gray_conv_pkg:
  - Default WIDTH/NREQ localparams.
  - Function gray2bin(WIDTH) (prefix XOR).
  - Function popcount used for the Hamming check.
  - Output-slot state enum (EMPTY, FULL).
- Sub-module rr_arbiter (NREQ): inputs req, en, ptr; outputs one-hot grant, grant index, any_grant. Reusable elsewhere in the codebase.
- Top holds output register, pointer and optional error logic.

Test Plan:
- Single requester: after reset, req_valid=4'b0001, gray 8'h0F, resp_ready=1 -> req_ready=4'b0001; next cycle resp_valid=1, resp_binary=8'h0A, resp_id=0.
- Conversion corners: gray 8'h00/8'hC0/8'hFF from requester 2 -> binary 8'h00/8'h80/8'hAA, resp_id=2 each.
- Fairness: all four valid continuously, resp_ready=1 -> resp_id sequence 0,1,2,3,0,1 with one result per cycle.
- Backpressure: resp_ready=0 for 5 cycles while resp_valid=1 -> req_ready=0, resp_binary/resp_id stable; resp_ready=1 -> next grant resumes at ptr.
- Reset mid-operation: assert rst_n=0 with resp_valid=1 -> immediately resp_valid=0, resp_binary=0; after release with all valid, first grant is requester 0.
- GRAY_ERR_CHK_EN: requester 1 sends 8'h01 then 8'h03 -> err_status=0; then 8'h00 (distance 2) -> err_status[1]=1; err_clr[1] pulse -> 0.
